// File: rtl/alu_pkg.sv
// Shared op codes, FSM encodings and op-class helpers for the sequential EX-stage ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_NOR    = 5'h05;
    localparam logic [4:0] OP_SLL    = 5'h06;
    localparam logic [4:0] OP_SRL    = 5'h07;
    localparam logic [4:0] OP_SRA    = 5'h08;
    localparam logic [4:0] OP_SLT    = 5'h09;
    localparam logic [4:0] OP_SLTU   = 5'h0A;
    localparam logic [4:0] OP_PASS_A = 5'h0B;
    // 0x0C is unassigned and behaves as an undefined op
    localparam logic [4:0] OP_BEQ    = 5'h0D;
    localparam logic [4:0] OP_BNE    = 5'h0E;
    localparam logic [4:0] OP_BLT    = 5'h0F;
    localparam logic [4:0] OP_BGE    = 5'h10;
    localparam logic [4:0] OP_BLTU   = 5'h11;
    localparam logic [4:0] OP_BGEU   = 5'h12;
    localparam logic [4:0] OP_PASS_B = 5'h13;
    localparam logic [4:0] OP_MUL    = 5'h18;
    localparam logic [4:0] OP_MULHU  = 5'h19;
    localparam logic [4:0] OP_DIV    = 5'h1A;
    localparam logic [4:0] OP_DIVU   = 5'h1B;
    localparam logic [4:0] OP_REM    = 5'h1C;
    localparam logic [4:0] OP_REMU   = 5'h1D;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / restoring-divide engine, one step per clock, first step on start.
// SEQ_ALU_EARLY_TERM_EN: multiplies report done once the remaining multiplier bits are zero.
module seq_alu_muldiv import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_cur, acc_nxt;
    logic [2*WIDTH-1:0] mcand_q, mcand_cur, mcand_nxt;
    logic [WIDTH-1:0]   mplr_q, mplr_cur, mplr_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         op_q;
    logic               mul_q, mul_cur, neg_quo_q, neg_rem_q, sdiv;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_sh, diff;

    assign sdiv  = (op == OP_DIV) || (op == OP_REM);
    assign mag_a = (sdiv && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sdiv && b[WIDTH-1]) ? -b : b;

    // On start the first step is taken straight from the operands so that
    // exactly WIDTH steps complete by the end of the WIDTH busy cycles.
    always_comb begin
        mul_cur   = mul_q;
        acc_cur   = acc_q;
        mcand_cur = mcand_q;
        mplr_cur  = mplr_q;
        if (start) begin
            mul_cur   = is_mul(op);
            acc_cur   = mul_cur ? '0 : {{WIDTH{1'b0}}, mag_a};
            mcand_cur = mul_cur ? {{WIDTH{1'b0}}, a} : '0;
            mplr_cur  = mul_cur ? b : mag_b;
        end
    end

    // Division: acc = {remainder, dividend/quotient}, mplr holds the divisor.
    assign rem_sh = {acc_cur[2*WIDTH-1:WIDTH], acc_cur[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mplr_cur};

    always_comb begin
        acc_nxt   = acc_cur;
        mcand_nxt = mcand_cur;
        mplr_nxt  = mplr_cur;
        if (mul_cur) begin
            acc_nxt   = acc_cur + (mplr_cur[0] ? mcand_cur : '0);
            mcand_nxt = mcand_cur << 1;
            mplr_nxt  = mplr_cur >> 1;
        end else if (!diff[WIDTH]) begin
            acc_nxt = {diff[WIDTH-1:0], acc_cur[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {rem_sh[WIDTH-1:0], acc_cur[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            mul_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start) begin
            acc_q     <= acc_nxt;
            mcand_q   <= mcand_nxt;
            mplr_q    <= mplr_nxt;
            cnt_q     <= CNT_W'(WIDTH - 1);
            op_q      <= op;
            mul_q     <= mul_cur;
            neg_quo_q <= sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= sdiv && a[WIDTH-1];
        end else if (cnt_q != '0) begin
            acc_q   <= acc_nxt;
            mcand_q <= mcand_nxt;
            mplr_q  <= mplr_nxt;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

`ifdef SEQ_ALU_EARLY_TERM_EN
    assign done = (cnt_q == '0) || (mul_q && (mplr_q == '0));
`else
    assign done = (cnt_q == '0);
`endif

    always_comb begin
        case (op_q)
            OP_MUL:          result = acc_q[WIDTH-1:0];
            OP_MULHU:        result = acc_q[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: result = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            default:         result = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// EX-stage ALU: single-cycle ops plus iterative mul/div behind a valid/ready handshake.
// SEQ_ALU_EARLY_TERM_EN: multiply by zero completes with latency 1 (see muldiv engine).
module seq_alu import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_in_1,
    input  logic [WIDTH-1:0] alu_in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_bcond,
    output logic             busy,
    input  logic             flush
);
    localparam int               SH_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic             accept, start, iter, special, quo, div_zero, div_ovf, mul_zero;
    logic             cap, cap_bc, sc_bc, lt_s, lt_u, eq, md_done;
    logic [WIDTH-1:0] sc_res, sp_res, cap_res, md_result, diff;
    logic [SH_W-1:0]  shamt;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign iter     = is_iterative(alu_op);
    assign start    = accept && !flush && iter && !special;

    assign shamt = alu_in_2[SH_W-1:0];
    assign diff  = alu_in_1 - alu_in_2;
    assign eq    = (alu_in_1 == alu_in_2);
    assign lt_s  = $signed(alu_in_1) < $signed(alu_in_2);
    assign lt_u  = alu_in_1 < alu_in_2;

    always_comb begin
        sc_res = '0;
        sc_bc  = 1'b0;
        case (alu_op)
            OP_ADD:    sc_res = alu_in_1 + alu_in_2;
            OP_SUB:    sc_res = diff;
            OP_AND:    sc_res = alu_in_1 & alu_in_2;
            OP_OR:     sc_res = alu_in_1 | alu_in_2;
            OP_XOR:    sc_res = alu_in_1 ^ alu_in_2;
            OP_NOR:    sc_res = ~(alu_in_1 | alu_in_2);
            OP_SLL:    sc_res = alu_in_1 << shamt;
            OP_SRL:    sc_res = alu_in_1 >> shamt;
            OP_SRA:    sc_res = $signed(alu_in_1) >>> shamt;
            OP_SLT:    sc_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:   sc_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_PASS_A: sc_res = alu_in_1;
            OP_PASS_B: sc_res = alu_in_2;
            OP_BEQ:    begin sc_res = diff; sc_bc = eq;    end
            OP_BNE:    begin sc_res = diff; sc_bc = !eq;   end
            OP_BLT:    begin sc_res = diff; sc_bc = lt_s;  end
            OP_BGE:    begin sc_res = diff; sc_bc = !lt_s; end
            OP_BLTU:   begin sc_res = diff; sc_bc = lt_u;  end
            OP_BGEU:   begin sc_res = diff; sc_bc = !lt_u; end
            default:   ;
        endcase
    end

    // Iterative ops whose answer is known up front skip the engine entirely.
    assign quo      = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign div_zero = iter && !is_mul(alu_op) && (alu_in_2 == '0);
    assign div_ovf  = ((alu_op == OP_DIV) || (alu_op == OP_REM)) &&
                      (alu_in_1 == MIN_VAL) && (&alu_in_2);
`ifdef SEQ_ALU_EARLY_TERM_EN
    assign mul_zero = is_mul(alu_op) && (alu_in_2 == '0);
`else
    assign mul_zero = 1'b0;
`endif
    assign special  = div_zero || div_ovf || mul_zero;
    assign sp_res   = div_zero ? (quo ? '1 : alu_in_1) :
                      (div_ovf && quo) ? alu_in_1 : '0;

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (alu_op),
        .a       (alu_in_1),
        .b       (alu_in_2),
        .done    (md_done),
        .result  (md_result)
    );

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        cap_res   = sc_res;
        cap_bc    = sc_bc;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (iter && !special) begin
                            state_nxt = S_BUSY;
                        end else begin
                            state_nxt = S_DONE;
                            cap       = 1'b1;
                            cap_res   = iter ? sp_res : sc_res;
                            cap_bc    = iter ? 1'b0 : sc_bc;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        state_nxt = S_DONE;
                        cap       = 1'b1;
                        cap_res   = md_result;
                        cap_bc    = 1'b0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            alu_result <= '0;
            alu_bcond  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == S_DONE);
            busy      <= (state_nxt == S_BUSY);
            if (cap) begin
                alu_result <= cap_res;
                alu_bcond  <= cap_bc;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, a negedge monitor checks them.
module tb_seq_alu;
    import alu_pkg::*;

`ifdef SEQ_ALU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = 5'h0;
    logic [31:0] alu_in_1 = '0;
    logic [31:0] alu_in_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result;
    logic        alu_bcond;
    logic        busy;
    logic        flush = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic        bc;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    bit   head_seen = 1'b0;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond),
        .busy       (busy),
        .flush      (flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Expected multiply latency for the build being simulated.
    function automatic int mlat(input logic [31:0] b);
        int idx = -1;
        for (int i = 0; i < 32; i++) if (b[i]) idx = i;
        if (!EARLY) return 33;
        return (idx < 0) ? 1 : idx + 2;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk({sbq[0].nm, "_result"}, alu_result, sbq[0].r);
                chk({sbq[0].nm, "_bcond"}, 32'(alu_bcond), 32'(sbq[0].bc));
                if (!head_seen) begin
                    chk({sbq[0].nm, "_latency"}, 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    void'(sbq.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge with in_valid still high.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic bc, input int lat,
                         input bit expect_out, input string nm);
        int waitc = 0;
        in_valid = 1'b1;
        alu_op   = op;
        alu_in_1 = a;
        alu_in_2 = b;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        if (expect_out) sbq.push_back('{r: r, bc: bc, lat: lat, acc: cyc, nm: nm});
    endtask

    task automatic drain();
        int waitc = 0;
        in_valid = 1'b0;
        while (sbq.size() != 0 && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
            head_seen = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", alu_result, 32'd0);
        chk("reset_bcond", 32'(alu_bcond), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops, issued back to back
        issue(OP_ADD,    32'd3,        32'd4,        32'd7,        0, 1, 1, "add");
        issue(OP_SUB,    32'd5,        32'd7,        32'hFFFFFFFE, 0, 1, 1, "sub");
        issue(OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 1, "and");
        issue(OP_OR,     32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 1, 1, "or");
        issue(OP_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1, 1, "xor");
        issue(OP_NOR,    32'h0F0F0000, 32'hF0F00000, 32'h0000FFFF, 0, 1, 1, "nor");
        issue(OP_SLL,    32'd1,        32'h24,       32'h10,       0, 1, 1, "sll_shamt_mask");
        issue(OP_SRL,    32'h80000000, 32'd31,       32'd1,        0, 1, 1, "srl");
        issue(OP_SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        0, 1, 1, "slt");
        issue(OP_SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        0, 1, 1, "sltu");
        issue(OP_PASS_A, 32'h12345678, 32'd9,        32'h12345678, 0, 1, 1, "pass_a");
        issue(OP_PASS_B, 32'h12345678, 32'd9,        32'd9,        0, 1, 1, "pass_b");
        issue(OP_BEQ,    32'd5,        32'd5,        32'd0,        1, 1, 1, "beq");
        issue(OP_BNE,    32'd5,        32'd5,        32'd0,        0, 1, 1, "bne");
        issue(OP_BLT,    32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1, 1, 1, "blt");
        issue(OP_BLTU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0, 1, 1, "bltu");
        issue(OP_BGE,    32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0, 1, 1, "bge");
        issue(OP_BGEU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1, 1, 1, "bgeu");
        issue(5'h0C,     32'd3,        32'd4,        32'd0,        0, 1, 1, "undef_0c");
        issue(5'h1F,     32'd3,        32'd4,        32'd0,        0, 1, 1, "undef_1f");
        drain();

        // Iterative ops and their shortcut cases
        issue(OP_MUL,   32'h00010000, 32'h00010000, 32'h0,        0, mlat(32'h00010000), 1, "mul_2p32");
        issue(OP_MULHU, 32'h00010000, 32'h00010000, 32'h1,        0, mlat(32'h00010000), 1, "mulhu_2p32");
        issue(OP_MULHU, 32'hFFFFFFFF, 32'd2,        32'h1,        0, mlat(32'd2),        1, "mulhu_b2");
        issue(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        0, mlat(32'hFFFFFFFF), 1, "mul_ones");
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, mlat(32'hFFFFFFFF), 1, "mulhu_ones");
        issue(OP_MUL,   32'd6,        32'd7,        32'd42,       0, mlat(32'd7),        1, "mul_6x7");
        issue(OP_MUL,   32'd5,        32'd0,        32'd0,        0, mlat(32'd0),        1, "mul_by0");
        issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33, 1, "div_m7_2");
        issue(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33, 1, "rem_m7_2");
        issue(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33, 1, "div_7_m2");
        issue(OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1,        0, 33, 1, "rem_7_m2");
        issue(OP_DIVU,  32'd100,      32'd7,        32'd14,       0, 33, 1, "divu_100_7");
        issue(OP_REMU,  32'd100,      32'd7,        32'd2,        0, 33, 1, "remu_100_7");
        issue(OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 0, 1,  1, "divu_by0");
        issue(OP_REMU,  32'd5,        32'd0,        32'd5,        0, 1,  1, "remu_by0");
        issue(OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 0, 1,  1, "div_by0");
        issue(OP_REM,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0, 1,  1, "rem_by0");
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1,  1, "div_ovf");
        issue(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1,  1, "rem_ovf");
        drain();

        // Backpressure: result held with in_ready low, then a no-bubble handoff
        out_ready = 1'b0;
        issue(OP_ADD, 32'd3, 32'd4, 32'd7, 0, 1, 1, "bp_add");
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_SUB, 32'd10, 32'd3, 32'd7, 0, 1, 1, "bp_next");
        drain();

        // Flush mid-division
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 0, 0, "flush_divu");
        in_valid = 1'b0;
        @(negedge clk);
        chk("divu_busy", 32'(busy), 32'd1);
        chk("divu_in_ready", 32'(in_ready), 32'd0);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(OP_ADD, 32'd1, 32'd1, 32'd2, 0, 1, 1, "post_flush_add");
        drain();

        // Asynchronous reset mid-multiply
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 0, 0, 0, "rst_mul");
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_result", alu_result, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 0, 1, 1, "sra");
        drain();

        repeat (40) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
